exhaustive_adder_checker: RTL and testbench
===========================================

# exhaustive_adder_checker

Synthesizable, clocked, self-checking exhaustive tester for an external WIDTH-bit adder/subtractor DUT. Sweeps every {a, b, cin} combination, compares the DUT's {cout, sum} against an internal golden model, counts mismatches and captures the first failing vector. It replaces the free-running simulation-only sweep with a start/done handshake, so it runs on the board as well as in the bench.

## Interface
Parameters:
- WIDTH, 4, operand width of a and b (≥1).
- SETTLE, 1, cycles each vector is held before sampling (≥1).
- STOP_ON_ERROR, 0, 1 ends the sweep at the first mismatch.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin sweep; honoured only when not busy.
- mode  in  1  0 = add, 1 = subtract; sampled on accepted start.
- a  out  WIDTH  operand A to DUT.
- b  out  WIDTH  operand B to DUT.
- cin  out  1  carry-in to DUT.
- dut_sum  in  WIDTH  DUT sum.
- dut_cout  in  1  DUT carry-out.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until next accepted start or reset.
- error  out  1  sticky: any mismatch since last start.
- err_count  out  2*WIDTH+2  mismatch count.
- fail_vec  out  2*WIDTH+1  {a,b,cin} of first mismatch; 0 if none.

## Operation
- Vector register vec, 2*WIDTH+1 bits: a = vec[2W:W+1], b = vec[W:1], cin = vec[0]. a/b/cin are driven straight from vec (registered), stable for the whole vector.
- Golden model, WIDTH+1 bits, zero-extended operands: mode 0 expected = a + b + cin; mode 1 expected = a + ~b + cin (cin = 1 means no borrow). Compared against {dut_cout, dut_sum}.
- FSM states: IDLE, APPLY, CHECK, DONE.
  - IDLE/DONE + start: vec←0, settle counter←0, error←0, err_count←0, fail_vec←0, done←0, busy←1, latch mode → APPLY.
  - APPLY: settle counter increments; at SETTLE−1 → CHECK.
  - CHECK: on mismatch, error←1, err_count+1, and fail_vec←vec if error was 0. Then → DONE if vec is all-ones, or if mismatch and STOP_ON_ERROR=1; otherwise vec+1, counter←0 → APPLY.
  - Entering DONE: busy←0, done←1.
- err_count never overflows: max 2^(2W+1) fits in 2W+2 bits.
- start while busy: ignored. Changes to mode mid-sweep: ignored.
- start held high in DONE: re-arms immediately (one sweep per accepted edge).

## Timing
- Reset (async, any state): state IDLE, vec 0 (a=b=cin=0), busy 0, done 0, error 0, err_count 0, fail_vec 0. Reset mid-sweep aborts with no partial done.
- busy rises on the edge that samples start. The first vector is on a/b/cin from that edge.
- Each vector occupies SETTLE+1 cycles: SETTLE in APPLY, 1 in CHECK. The DUT output is sampled at the end of CHECK.
- Full sweep: done rises 2^(2W+1)·(SETTLE+1) cycles after the start edge.
- error, err_count and fail_vec update on the CHECK-exit edge of the failing vector. done and the final counts are valid on the same edge.

## Structure
- Shared package exh_tester_pkg: FSM state encodings (IDLE=0, APPLY=1, CHECK=2, DONE=3) and MODE_ADD/MODE_SUB constants.
- One sub-module, adder_golden: combinational, parameter WIDTH; inputs a, b, cin, mode; output expected[WIDTH:0].
- Top holds the FSM, vec, settle counter and result registers.

## Test plan
- WIDTH=4, SETTLE=1, correct adder, mode 0, start pulse → done 1024 cycles later, error 0, err_count 0, fail_vec 0.
- Same setup, DUT sum[0] stuck-at-0 → err_count 256, error 1, fail_vec 9'h001 (a=0, b=0, cin=1).
- Same fault, STOP_ON_ERROR=1 → done 4 cycles after start, err_count 1, fail_vec 9'h001.
- mode 1 with correct subtractor → err_count 0. mode 1 with correct adder as DUT → error 1, fail_vec 9'h000 (expected 5'h0F, got 5'h00).
- WIDTH=2, SETTLE=3 → done after 128 cycles. start pulsed at cycle 50 → ignored, counts unchanged.
- rst asserted at cycle 300 of a WIDTH=4 sweep → all outputs 0 immediately. A fresh start then completes in 1024 cycles with clean results.

Source files
------------

// File: rtl/exhaustive_adder_checker_pkg.sv
// Shared definitions for the exhaustive adder checker: FSM encoding and
// add/subtract mode constants.
package exh_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // The settle counter needs at least one bit, even when SETTLE is 1.
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/exhaustive_adder_checker_if.sv
// Bus between the checker and its surroundings: control handshake, operand
// drive to the external adder, the adder's response and the sweep results.
interface exhaustive_adder_checker_if #(
    parameter int WIDTH = 4
);
    // start is a one-cycle request taken only while busy is low; busy rises on
    // the accepting edge and done is held until the next accepted start.
    logic                 start;
    logic                 mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 cin;
    logic [WIDTH-1:0]     dut_sum;
    logic                 dut_cout;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [2*WIDTH+1:0]   err_count;
    logic [2*WIDTH:0]     fail_vec;

    modport master (
        input  start, mode, dut_sum, dut_cout,
        output a, b, cin, busy, done, error, err_count, fail_vec
    );

    modport slave (
        output start, mode, dut_sum, dut_cout,
        input  a, b, cin, busy, done, error, err_count, fail_vec
    );
endinterface

// File: rtl/exhaustive_adder_checker_golden.sv
// Reference adder/subtractor: WIDTH+1-bit result from zero-extended operands.
module adder_golden
    import exh_tester_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic [WIDTH:0]   expected
);

    logic [WIDTH-1:0] w_b_eff;

    // Subtract is a + ~b + cin, so cin = 1 means "no borrow in".
    always_comb begin
        w_b_eff  = (mode == MODE_SUB) ? ~b : b;
        expected = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/exhaustive_adder_checker.sv
// Exhaustive tester: sweeps every {a, b, cin}, compares the external adder
// against adder_golden, counts mismatches and captures the first failing vector.
module exhaustive_adder_checker
    import exh_tester_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE        = 1,
    parameter int STOP_ON_ERROR = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    exhaustive_adder_checker_if.master   bus,
    output state_t                       o_dbg_state
);

    localparam int VW = 2*WIDTH + 1;
    localparam int CW = cnt_width(SETTLE);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [VW-1:0] VEC_ONE     = VW'(1);
    localparam logic [VW:0]   ERR_ONE     = (VW+1)'(1);

    state_t          r_state;
    logic [VW-1:0]   r_vec;
    logic [CW-1:0]   r_cnt;
    logic            r_mode;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic [VW:0]     r_err_count;
    logic [VW-1:0]   r_fail_vec;

    logic [WIDTH:0]  w_expected;
    logic            w_mismatch;
    logic            w_last_vec;

    adder_golden #(.WIDTH(WIDTH)) u_golden (
        .a        (r_vec[VW-1:WIDTH+1]),
        .b        (r_vec[WIDTH:1]),
        .cin      (r_vec[0]),
        .mode     (r_mode),
        .expected (w_expected)
    );

    assign w_mismatch = (w_expected != {bus.dut_cout, bus.dut_sum});
    assign w_last_vec = &r_vec;

    assign bus.a         = r_vec[VW-1:WIDTH+1];
    assign bus.b         = r_vec[WIDTH:1];
    assign bus.cin       = r_vec[0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
    assign bus.err_count = r_err_count;
    assign bus.fail_vec  = r_fail_vec;
    assign o_dbg_state   = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_vec       <= '0;
            r_cnt       <= '0;
            r_mode      <= MODE_ADD;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= '0;
            r_fail_vec  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_vec       <= '0;
                        r_cnt       <= '0;
                        r_error     <= 1'b0;
                        r_err_count <= '0;
                        r_fail_vec  <= '0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_mode      <= bus.mode;
                        r_state     <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_CHECK: begin
                    if (w_mismatch) begin
                        r_error     <= 1'b1;
                        r_err_count <= r_err_count + ERR_ONE;
                        if (!r_error) begin
                            r_fail_vec <= r_vec;
                        end
                    end
                    if (w_last_vec || (w_mismatch && (STOP_ON_ERROR != 0))) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_vec   <= r_vec + VEC_ONE;
                        r_cnt   <= '0;
                        r_state <= ST_APPLY;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exhaustive_adder_checker.sv
// Bench for exhaustive_adder_checker: three instances (W4/S1, W4/S1 stop-on-error,
// W2/S3) each driving a behavioural adder stand-in with optional stuck-at fault.
module tb_exhaustive_adder_checker;
  import exh_tester_pkg::*;

  typedef struct packed {
    logic [15:0] lat;
    logic        err;
    logic [9:0]  cnt;
    logic [8:0]  fv;
  } exp_t;

  logic clk;
  logic rst;
  bit   dut_sub;
  bit   dut_fault;
  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];

  state_t st_a, st_b, st_c;
  int res_a, res_b, res_c;

  exhaustive_adder_checker_if #(.WIDTH(4)) if_a ();
  exhaustive_adder_checker_if #(.WIDTH(4)) if_b ();
  exhaustive_adder_checker_if #(.WIDTH(2)) if_c ();

  exhaustive_adder_checker #(.WIDTH(4), .SETTLE(1), .STOP_ON_ERROR(0)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.master), .o_dbg_state(st_a));
  exhaustive_adder_checker #(.WIDTH(4), .SETTLE(1), .STOP_ON_ERROR(1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.master), .o_dbg_state(st_b));
  exhaustive_adder_checker #(.WIDTH(2), .SETTLE(3), .STOP_ON_ERROR(0)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c.master), .o_dbg_state(st_c));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- adder under test (behavioural stand-in) ----------------
  // Subtractor: difference with borrow-in = ~cin, cout = "no borrow out".
  function automatic int dut_fn(input int w, input int a, input int b, input int c,
                                input bit sub, input bit fault);
    int mask, s, co, t;
    mask = (1 << w) - 1;
    if (sub) begin
      t  = a - b - (1 - c);
      co = (t >= 0) ? 1 : 0;
      s  = t & mask;
    end else begin
      t  = a + b + c;
      co = t >> w;
      s  = t & mask;
    end
    if (fault) s = s & ~1;
    return (co << w) | s;
  endfunction

  always_comb res_a = dut_fn(4, int'(if_a.a), int'(if_a.b), int'(if_a.cin), dut_sub, dut_fault);
  always_comb res_b = dut_fn(4, int'(if_b.a), int'(if_b.b), int'(if_b.cin), dut_sub, dut_fault);
  always_comb res_c = dut_fn(2, int'(if_c.a), int'(if_c.b), int'(if_c.cin), dut_sub, dut_fault);

  assign if_a.dut_sum  = res_a[3:0];
  assign if_a.dut_cout = res_a[4];
  assign if_b.dut_sum  = res_b[3:0];
  assign if_b.dut_cout = res_b[4];
  assign if_c.dut_sum  = res_c[1:0];
  assign if_c.dut_cout = res_c[2];

  // ---------------- reference model for a whole sweep ----------------
  function automatic exp_t model(input int w, input int settle, input bit md,
                                 input bit sub_dut, input bit fault, input bit stop);
    exp_t e;
    int total, mask, n, first, lat, a, b, c, gold, got;
    total = 1 << (2*w + 1);
    mask  = (1 << w) - 1;
    n     = 0;
    first = -1;
    lat   = total * (settle + 1);
    for (int v = 0; v < total; v++) begin
      a    = (v >> (w + 1)) & mask;
      b    = (v >> 1) & mask;
      c    = v & 1;
      gold = md ? (a - b - 1 + c + (1 << w)) : (a + b + c);
      got  = dut_fn(w, a, b, c, sub_dut, fault);
      if (gold != got) begin
        n++;
        if (first < 0) first = v;
        if (stop) begin
          lat = (v + 1) * (settle + 1);
          break;
        end
      end
    end
    e.lat = 16'(lat);
    e.err = (n != 0);
    e.cnt = 10'(n);
    e.fv  = (first < 0) ? 9'd0 : 9'(first);
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_start(input int sel, input logic s, input logic md);
    case (sel)
      0:       begin if_a.start = s; if_a.mode = md; end
      1:       begin if_b.start = s; if_b.mode = md; end
      default: begin if_c.start = s; if_c.mode = md; end
    endcase
  endtask

  task automatic sample(input int sel, output logic dn, output logic bz, output logic er,
                        output logic [9:0] cnt, output logic [8:0] fv, output logic [8:0] vec);
    case (sel)
      0: begin
        dn = if_a.done; bz = if_a.busy; er = if_a.error;
        cnt = if_a.err_count; fv = if_a.fail_vec; vec = {if_a.a, if_a.b, if_a.cin};
      end
      1: begin
        dn = if_b.done; bz = if_b.busy; er = if_b.error;
        cnt = if_b.err_count; fv = if_b.fail_vec; vec = {if_b.a, if_b.b, if_b.cin};
      end
      default: begin
        dn = if_c.done; bz = if_c.busy; er = if_c.error;
        cnt = 10'(if_c.err_count); fv = 9'(if_c.fail_vec); vec = 9'({if_c.a, if_c.b, if_c.cin});
      end
    endcase
  endtask

  function automatic exp_t model_for(input int sel, input bit md, input bit sub_dut, input bit fault);
    case (sel)
      0:       return model(4, 1, md, sub_dut, fault, 1'b0);
      1:       return model(4, 1, md, sub_dut, fault, 1'b1);
      default: return model(2, 3, md, sub_dut, fault, 1'b0);
    endcase
  endfunction

  // Scoreboard side: after the start edge, count cycles to done, pop and compare.
  // If poke is set, a start pulse with flipped mode is driven at cycle 50.
  task automatic wait_and_compare(input int sel, input string name, input bit poke, input bit md);
    exp_t e;
    int cyc;
    bit fin;
    logic dn, bz, er;
    logic [9:0] cnt;
    logic [8:0] fv, vec;
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke && cyc == 50) set_start(sel, 1'b1, ~md);
      if (poke && cyc == 51) set_start(sel, 1'b0, md);
      sample(sel, dn, bz, er, cnt, fv, vec);
      if (dn) fin = 1;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (!fin) begin
      n_errors++;
      $display("FAIL %s timeout: done not seen within %0d cycles, required %0d", name, cyc, e.lat);
    end else if (cyc !== int'(e.lat)) begin
      n_errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, e.lat);
    end
    n_checks++;
    if (bz !== 1'b0) begin
      n_errors++;
      $display("FAIL %s busy_at_done: got %b, required 0", name, bz);
    end
    n_checks++;
    if (er !== e.err) begin
      n_errors++;
      $display("FAIL %s error: got %b, required %b", name, er, e.err);
    end
    n_checks++;
    if (cnt !== e.cnt) begin
      n_errors++;
      $display("FAIL %s err_count: got %0d, required %0d", name, cnt, e.cnt);
    end
    n_checks++;
    if (fv !== e.fv) begin
      n_errors++;
      $display("FAIL %s fail_vec: got %h, required %h", name, fv, e.fv);
    end
  endtask

  task automatic run_sweep(input int sel, input bit md, input bit sub_dut, input bit fault,
                           input string name, input bit poke);
    logic dn, bz, er;
    logic [9:0] cnt;
    logic [8:0] fv, vec;
    dut_sub   = sub_dut;
    dut_fault = fault;
    @(negedge clk);
    set_start(sel, 1'b1, md);
    exp_q.push_back(model_for(sel, md, sub_dut, fault));
    @(posedge clk);
    #1;
    set_start(sel, 1'b0, md);
    sample(sel, dn, bz, er, cnt, fv, vec);
    n_checks++;
    if (bz !== 1'b1 || dn !== 1'b0) begin
      n_errors++;
      $display("FAIL %s start_edge: busy=%b done=%b, required busy=1 done=0", name, bz, dn);
    end
    n_checks++;
    if (vec !== 9'd0) begin
      n_errors++;
      $display("FAIL %s first_vec: got %h, required 000", name, vec);
    end
    wait_and_compare(sel, name, poke, md);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({if_a.busy, if_a.done, if_a.error} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: got busy/done/error=%b, required 000",
               {if_a.busy, if_a.done, if_a.error});
    end
    n_checks++;
    if (if_a.err_count !== 10'd0 || if_a.fail_vec !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_counts: got err_count=%0d fail_vec=%h, required 0/0",
               if_a.err_count, if_a.fail_vec);
    end
    n_checks++;
    if ({if_a.a, if_a.b, if_a.cin} !== 9'd0 || st_a !== ST_IDLE) begin
      n_errors++;
      $display("FAIL reset_vec_state: got vec=%h state=%0d, required 000/0",
               {if_a.a, if_a.b, if_a.cin}, st_a);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_clean();
    logic dn, bz, er;
    logic [9:0] cnt;
    logic [8:0] fv, vec;
    run_sweep(0, MODE_ADD, 1'b0, 1'b0, "add_clean", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    sample(0, dn, bz, er, cnt, fv, vec);
    n_checks++;
    if (dn !== 1'b1 || st_a !== ST_DONE) begin
      n_errors++;
      $display("FAIL done_held: got done=%b state=%0d, required 1/3", dn, st_a);
    end
  endtask

  task automatic test_stuck_fault();
    run_sweep(0, MODE_ADD, 1'b0, 1'b1, "stuck_sum0", 1'b0);
  endtask

  task automatic test_stop_on_error();
    run_sweep(1, MODE_ADD, 1'b0, 1'b1, "stop_on_error", 1'b0);
  endtask

  task automatic test_subtract();
    run_sweep(0, MODE_SUB, 1'b1, 1'b0, "sub_clean", 1'b0);
    run_sweep(0, MODE_SUB, 1'b0, 1'b0, "sub_vs_adder", 1'b0);
  endtask

  task automatic test_start_ignored();
    run_sweep(2, MODE_ADD, 1'b0, 1'b0, "w2_s3_ignore_start", 1'b1);
  endtask

  task automatic test_back_to_back();
    logic dn, bz, er;
    logic [9:0] cnt;
    logic [8:0] fv, vec;
    dut_sub   = 1'b0;
    dut_fault = 1'b1;
    @(negedge clk);
    set_start(1, 1'b1, MODE_ADD);
    exp_q.push_back(model_for(1, MODE_ADD, 1'b0, 1'b1));
    @(posedge clk);
    #1;
    sample(1, dn, bz, er, cnt, fv, vec);
    n_checks++;
    if (bz !== 1'b1 || dn !== 1'b0 || er !== 1'b0 || cnt !== 10'd0) begin
      n_errors++;
      $display("FAIL rearm_from_done: busy=%b done=%b error=%b cnt=%0d, required 1/0/0/0",
               bz, dn, er, cnt);
    end
    // start stays high for two more edges while busy; those must be ignored
    wait_and_compare_held();
  endtask

  task automatic wait_and_compare_held();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    set_start(1, 1'b0, MODE_ADD);
    // two of the expected four cycles have already elapsed
    exp_q[0].lat = exp_q[0].lat - 16'd2;
    wait_and_compare(1, "back_to_back", 1'b0, MODE_ADD);
  endtask

  task automatic test_reset_mid_sweep();
    logic dn, bz, er;
    logic [9:0] cnt;
    logic [8:0] fv, vec;
    int seen_done;
    dut_sub   = 1'b0;
    dut_fault = 1'b1;
    @(negedge clk);
    set_start(0, 1'b1, MODE_ADD);
    @(posedge clk);
    #1;
    set_start(0, 1'b0, MODE_ADD);
    repeat (300) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sample(0, dn, bz, er, cnt, fv, vec);
    n_checks++;
    if ({bz, dn, er} !== 3'b000 || cnt !== 10'd0 || fv !== 9'd0 || vec !== 9'd0) begin
      n_errors++;
      $display("FAIL mid_reset: busy=%b done=%b error=%b cnt=%0d fv=%h vec=%h, required all 0",
               bz, dn, er, cnt, fv, vec);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat ($urandom_range(5, 20)) begin
      @(posedge clk);
      #1;
      if (if_a.done === 1'b1 || if_a.busy === 1'b1) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      n_errors++;
      $display("FAIL post_reset_idle: busy/done seen %0d cycles, required 0", seen_done);
    end
    run_sweep(0, MODE_ADD, 1'b0, 1'b0, "fresh_after_reset", 1'b0);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    dut_sub   = 1'b0;
    dut_fault = 1'b0;
    if_a.start = 1'b0; if_a.mode = 1'b0;
    if_b.start = 1'b0; if_b.mode = 1'b0;
    if_c.start = 1'b0; if_c.mode = 1'b0;
    rst = 1'b1;
    test_reset();
    test_add_clean();
    test_stuck_fault();
    test_stop_on_error();
    test_back_to_back();
    test_subtract();
    test_start_ignored();
    test_reset_mid_sweep();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
